ct_hpcp_event_cnt: RTL and testbench

- One hardware performance counter slice in the HPCP; it is the producer side of the overflow flag.
- Accumulates per-cycle event counts from the core, is loaded by CSR writes qualified by the L2-count completion flag, and emits the single-cycle counter_overflow_x pulse.
- counter_overflow_x feeds that counter's sticky overflow (cntof) register.
- cnt_value is read back by the CSR read mux.

---
 rtl/ct_hpcp_pkg.sv | 11 +
 rtl/ct_hpcp_cnt_acc.sv | 54 +++++
 rtl/ct_hpcp_event_cnt.sv | 79 +++++++
 tb/tb_ct_hpcp_event_cnt.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ct_hpcp_pkg.sv
// Shared defaults for the HPCP event counter slice.
//   HPCP_CNT_W  : default counter width (even, 32..64)
//   HPCP_EVT_W  : default width of the per-cycle event count
//   HPCP_HALF_W : width of one CSR-writable half of the counter
package ct_hpcp_pkg;

    localparam int unsigned HPCP_CNT_W  = 64;
    localparam int unsigned HPCP_EVT_W  = 3;
    localparam int unsigned HPCP_HALF_W = HPCP_CNT_W / 2;

endpackage

// File: rtl/ct_hpcp_cnt_acc.sv
// Stage-2 accumulate datapath for one HPCP counter: adds the captured event count
// to the current value with carry-out, and lets a qualified CSR write replace either
// half. Purely combinational.
//   cnt_value : current counter value
//   evt_vld   : stage-1 event valid
//   evt_num   : stage-1 event count (zero-extended into the adder)
//   wr_lo     : qualified write of the low half
//   wr_hi     : qualified write of the high half
//   wdata     : write data for whichever half is written
//   cnt_nxt   : next counter value
//   ovf_nxt   : carry out of the accumulate (never set on a write cycle)
module ct_hpcp_cnt_acc
    import ct_hpcp_pkg::*;
#(
    parameter int unsigned CNT_W = HPCP_CNT_W,
    parameter int unsigned EVT_W = HPCP_EVT_W
) (
    input  logic [CNT_W-1:0]   cnt_value,
    input  logic               evt_vld,
    input  logic [EVT_W-1:0]   evt_num,
    input  logic               wr_lo,
    input  logic               wr_hi,
    input  logic [CNT_W/2-1:0] wdata,
    output logic [CNT_W-1:0]   cnt_nxt,
    output logic               ovf_nxt
);

    localparam int unsigned HALF_W = CNT_W / 2;

    logic [CNT_W:0] inc;
    logic [CNT_W:0] sum;

    always_comb begin
        inc = '0;
        if (evt_vld) begin
            inc[EVT_W-1:0] = evt_num;
        end
        sum     = {1'b0, cnt_value} + inc;
        cnt_nxt = sum[CNT_W-1:0];
        ovf_nxt = sum[CNT_W];
        // A write wins: the increment of this cycle is dropped, not merged.
        if (wr_lo || wr_hi) begin
            cnt_nxt = cnt_value;
            ovf_nxt = 1'b0;
            if (wr_lo) begin
                cnt_nxt[HALF_W-1:0] = wdata;
            end
            if (wr_hi) begin
                cnt_nxt[CNT_W-1:HALF_W] = wdata;
            end
        end
    end

endmodule

// File: rtl/ct_hpcp_event_cnt.sv
// One HPCP performance counter slice. Captures per-cycle event counts (stage 1),
// accumulates them into the counter (stage 2), accepts half-width CSR writes that
// are qualified by l2cnt_cmplt_ff, and emits a one-cycle overflow pulse per wrap.
//   hpcp_clk           : clock
//   cpurst_b           : asynchronous active-low reset
//   cnt_en             : counting permitted (gates capture only)
//   event_vld          : event_num valid this cycle
//   event_num          : number of events this cycle
//   cnt_wen_lo         : CSR write of the low half
//   cnt_wen_hi         : CSR write of the high half
//   l2cnt_cmplt_ff     : write qualifier
//   hpcp_wdata         : CSR write data
//   cnt_value          : current counter value
//   counter_overflow_x : single-cycle overflow pulse
module ct_hpcp_event_cnt
    import ct_hpcp_pkg::*;
#(
    parameter int unsigned CNT_W = HPCP_CNT_W,
    parameter int unsigned EVT_W = HPCP_EVT_W
) (
    input  logic               hpcp_clk,
    input  logic               cpurst_b,
    input  logic               cnt_en,
    input  logic               event_vld,
    input  logic [EVT_W-1:0]   event_num,
    input  logic               cnt_wen_lo,
    input  logic               cnt_wen_hi,
    input  logic               l2cnt_cmplt_ff,
    input  logic [CNT_W/2-1:0] hpcp_wdata,
    output logic [CNT_W-1:0]   cnt_value,
    output logic               counter_overflow_x
);

    logic             evt_vld_s1;
    logic [EVT_W-1:0] evt_num_s1;
    logic             wr_lo;
    logic             wr_hi;
    logic [CNT_W-1:0] cnt_nxt;
    logic             ovf_nxt;

    // Unqualified write strobes are dropped outright, never held for later.
    assign wr_lo = cnt_wen_lo & l2cnt_cmplt_ff;
    assign wr_hi = cnt_wen_hi & l2cnt_cmplt_ff;

    always_ff @(posedge hpcp_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            evt_vld_s1 <= 1'b0;
            evt_num_s1 <= '0;
        end else begin
            evt_vld_s1 <= event_vld & cnt_en;
            evt_num_s1 <= event_num;
        end
    end

    ct_hpcp_cnt_acc #(
        .CNT_W (CNT_W),
        .EVT_W (EVT_W)
    ) u_acc (
        .cnt_value (cnt_value),
        .evt_vld   (evt_vld_s1),
        .evt_num   (evt_num_s1),
        .wr_lo     (wr_lo),
        .wr_hi     (wr_hi),
        .wdata     (hpcp_wdata),
        .cnt_nxt   (cnt_nxt),
        .ovf_nxt   (ovf_nxt)
    );

    always_ff @(posedge hpcp_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            cnt_value          <= '0;
            counter_overflow_x <= 1'b0;
        end else begin
            cnt_value          <= cnt_nxt;
            counter_overflow_x <= ovf_nxt;
        end
    end

endmodule

// File: tb/tb_ct_hpcp_event_cnt.sv
// Self-checking bench for ct_hpcp_event_cnt: directed scenarios with literal
// expectations, then randomized traffic compared every cycle with a reference model.
module tb_ct_hpcp_event_cnt;

    localparam int unsigned CNT_W = 64;
    localparam int unsigned EVT_W = 3;

    logic              hpcp_clk = 1'b0;
    logic              cpurst_b;
    logic              cnt_en;
    logic              event_vld;
    logic [EVT_W-1:0]  event_num;
    logic              cnt_wen_lo;
    logic              cnt_wen_hi;
    logic              l2cnt_cmplt_ff;
    logic [31:0]       hpcp_wdata;
    logic [CNT_W-1:0]  cnt_value;
    logic              counter_overflow_x;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    ct_hpcp_event_cnt #(
        .CNT_W (CNT_W),
        .EVT_W (EVT_W)
    ) dut (
        .hpcp_clk           (hpcp_clk),
        .cpurst_b           (cpurst_b),
        .cnt_en             (cnt_en),
        .event_vld          (event_vld),
        .event_num          (event_num),
        .cnt_wen_lo         (cnt_wen_lo),
        .cnt_wen_hi         (cnt_wen_hi),
        .l2cnt_cmplt_ff     (l2cnt_cmplt_ff),
        .hpcp_wdata         (hpcp_wdata),
        .cnt_value          (cnt_value),
        .counter_overflow_x (counter_overflow_x)
    );

    always #5 hpcp_clk = ~hpcp_clk;

    // Reference model. An event accepted at one edge is worth its count at the next
    // edge; a qualified write at that edge replaces the addressed halves and throws
    // the pending count away. Overflow is the carry out of the 64-bit add.
    logic [CNT_W-1:0] m_cnt  = '0;
    logic             m_ovf  = 1'b0;
    int unsigned      m_pend = 0;

    always @(posedge hpcp_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            m_cnt  <= '0;
            m_ovf  <= 1'b0;
            m_pend <= 0;
        end else begin
            logic [CNT_W:0]   total;
            logic [CNT_W-1:0] nv;
            if (l2cnt_cmplt_ff && (cnt_wen_lo || cnt_wen_hi)) begin
                nv = m_cnt;
                if (cnt_wen_lo) nv = {nv[63:32], hpcp_wdata};
                if (cnt_wen_hi) nv = {hpcp_wdata, nv[31:0]};
                m_cnt <= nv;
                m_ovf <= 1'b0;
            end else begin
                total = {1'b0, m_cnt} + 65'(m_pend);
                m_cnt <= total[CNT_W-1:0];
                m_ovf <= total[CNT_W];
            end
            m_pend <= (event_vld && cnt_en) ? int'(event_num) : 0;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge hpcp_clk) begin
        if (chk_en && cpurst_b) begin
            checks++;
            if (cnt_value !== m_cnt) begin
                errors++;
                $display("FAIL model_cnt t=%0t got=%h exp=%h", $time, cnt_value, m_cnt);
            end
            checks++;
            if (counter_overflow_x !== m_ovf) begin
                errors++;
                $display("FAIL model_ovf t=%0t got=%b exp=%b", $time, counter_overflow_x,
                         m_ovf);
            end
        end
    end

    task automatic check(input string name, input logic [CNT_W-1:0] act,
                         input logic [CNT_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge hpcp_clk);
        #1;
    endtask

    task automatic drive(input logic vld, input logic en, input logic [EVT_W-1:0] num,
                         input logic wlo, input logic whi, input logic l2,
                         input logic [31:0] wd);
        event_vld      = vld;
        cnt_en         = en;
        event_num      = num;
        cnt_wen_lo     = wlo;
        cnt_wen_hi     = whi;
        l2cnt_cmplt_ff = l2;
        hpcp_wdata     = wd;
    endtask

    task automatic idle();
        drive(1'b0, 1'b1, '0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    initial begin
        cpurst_b = 1'b0;
        idle();
        repeat (3) step();
        cpurst_b = 1'b1;
        chk_en   = 1'b1;
        check("reset_cnt", cnt_value, 64'h0);
        check("reset_ovf", 64'(counter_overflow_x), 64'h0);

        // Single event of 5 lands two edges after presentation.
        drive(1'b1, 1'b1, 3'd5, 1'b0, 1'b0, 1'b0, '0);
        step();
        idle();
        check("evt5_not_yet", cnt_value, 64'h0);
        step();
        check("evt5_cnt", cnt_value, 64'd5);
        check("evt5_ovf", 64'(counter_overflow_x), 64'h0);

        // Preload near all-ones, then +3 wraps to 1 with a single overflow pulse.
        drive(1'b0, 1'b1, '0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFE);
        step();
        drive(1'b0, 1'b1, '0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF);
        step();
        check("preload", cnt_value, 64'hFFFF_FFFF_FFFF_FFFE);
        drive(1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, '0);
        step();
        idle();
        step();
        check("wrap_cnt", cnt_value, 64'h1);
        check("wrap_ovf", 64'(counter_overflow_x), 64'h1);
        step();
        check("wrap_ovf_drop", 64'(counter_overflow_x), 64'h0);

        // Unqualified write ignored; qualified low write keeps the high half.
        drive(1'b0, 1'b1, '0, 1'b0, 1'b1, 1'b1, 32'h55);
        step();
        drive(1'b0, 1'b1, '0, 1'b1, 1'b0, 1'b0, 32'h1234);
        step();
        idle();
        step();
        check("wr_unqual", cnt_value, 64'h0000_0055_0000_0001);
        drive(1'b0, 1'b1, '0, 1'b1, 1'b0, 1'b1, 32'h1234);
        step();
        check("wr_lo", cnt_value, 64'h0000_0055_0000_1234);

        // Event in stage 1 coincident with a high write is discarded.
        drive(1'b1, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0, '0);
        step();
        drive(1'b0, 1'b1, '0, 1'b0, 1'b1, 1'b1, 32'hA);
        step();
        check("wr_hi_cnt", cnt_value, 64'h0000_000A_0000_1234);
        check("wr_hi_ovf", 64'(counter_overflow_x), 64'h0);
        idle();
        step();
        check("wr_hi_drop", cnt_value, 64'h0000_000A_0000_1234);

        // cnt_en gates capture; dropping it after capture does not cancel the event.
        drive(1'b1, 1'b0, 3'd7, 1'b0, 1'b0, 1'b0, '0);
        step();
        idle();
        step();
        check("en_off", cnt_value, 64'h0000_000A_0000_1234);
        drive(1'b1, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, '0);
        step();
        drive(1'b1, 1'b0, 3'd7, 1'b0, 1'b0, 1'b0, '0);
        step();
        idle();
        step();
        check("en_fall", cnt_value, 64'h0000_000A_0000_1236);

        // All-ones plus 1 on two consecutive cycles: 0 then 1, one pulse.
        drive(1'b0, 1'b1, '0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF);
        step();
        check("both_halves", cnt_value, 64'hFFFF_FFFF_FFFF_FFFF);
        drive(1'b1, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, '0);
        step();
        step();
        idle();
        check("b2b_cnt0", cnt_value, 64'h0);
        check("b2b_ovf0", 64'(counter_overflow_x), 64'h1);
        step();
        check("b2b_cnt1", cnt_value, 64'h1);
        check("b2b_ovf1", 64'(counter_overflow_x), 64'h0);

        // Asynchronous reset mid-stream clears immediately.
        drive(1'b1, 1'b1, 3'd6, 1'b0, 1'b0, 1'b0, '0);
        step();
        #2;
        cpurst_b = 1'b0;
        #1;
        check("async_cnt", cnt_value, 64'h0);
        check("async_ovf", 64'(counter_overflow_x), 64'h0);
        step();
        cpurst_b = 1'b1;
        idle();
        step();
        check("async_drop", cnt_value, 64'h0);

        // Randomized traffic; writes favour all-ones data so wraps happen often.
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] wd;
            logic        wr;
            wd = ($urandom_range(0, 2) == 0) ? 32'hFFFF_FFFF : $urandom;
            wr = ($urandom_range(0, 7) == 0);
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) != 0),
                  3'($urandom), wr & 1'($urandom), wr & 1'($urandom),
                  1'($urandom_range(0, 3) != 0), wd);
            if ($urandom_range(0, 299) == 0) begin
                #2;
                cpurst_b = 1'b0;
                step();
                cpurst_b = 1'b1;
            end else begin
                step();
            end
        end

        idle();
        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
